config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 109 ++++++++++
 tb/tb_config_chain_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Purpose: loads NUM_CHAINS parallel shift chains of CHAIN_LEN bits, or rotates them to read back and verify.
// Latency: done pulses one cycle after the CHAIN_LEN-th accepted beat; mem_out is directly registered.
// Backpressure: cfg_ready is high only in SHIFT; cfg_valid=0 there stalls with all state held.
module config_chain_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 16
) (
  input  logic                             prog_clk,
  input  logic                             pReset,
  input  logic                             start,
  input  logic                             verify,
  input  logic [NUM_CHAINS-1:0]            cfg_data,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0]  mem_out,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0]  mem_outb
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int MW = NUM_CHAINS * CHAIN_LEN;
  localparam logic [CW-1:0] LAST_BEAT = CW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;   // 1 = readback-verify, 0 = load
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   mem_q, mem_d;
  logic [CHAIN_LEN-1:0] chain;
  logic            mismatch;

  // Next-state: FSM transitions, beat counting, chain shift/rotate and sticky error.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    chain    = '0;
    mismatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          mode_d  = verify;
          cnt_d   = '0;
          // A fresh verify pass starts with a clean error flag; loads leave it alone.
          if (verify) err_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_valid) begin
          cnt_d = cnt_q + CW'(1);
          for (int c = 0; c < NUM_CHAINS; c++) begin
            chain = mem_q[c*CHAIN_LEN +: CHAIN_LEN];
            if (mode_q) begin
              // Rotate so that CHAIN_LEN verify beats restore the original contents.
              mem_d[c*CHAIN_LEN +: CHAIN_LEN] = {chain[CHAIN_LEN-2:0], chain[CHAIN_LEN-1]};
              if (chain[CHAIN_LEN-1] != cfg_data[c]) mismatch = 1'b1;
            end else begin
              mem_d[c*CHAIN_LEN +: CHAIN_LEN] = {chain[CHAIN_LEN-2:0], cfg_data[c]};
            end
          end
          if (mismatch) err_d = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over any request or beat.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign cfg_ready = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign mem_out   = mem_q;
  assign mem_outb  = ~mem_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with two chains of four bits.
// Each step drives inputs, waits one rising edge, then samples 1 ns later.
// Table rows cover load/verify/error paths; hand sequences cover stalls and mid-shift reset.
module tb_config_chain_loader;

  logic       prog_clk;
  logic       pReset;
  logic       start;
  logic       verify;
  logic [1:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] mem_out;
  logic [7:0] mem_outb;

  int n_checks;
  int n_fail;

  config_chain_loader #(.NUM_CHAINS(2), .CHAIN_LEN(4)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .start     (start),
    .verify    (verify),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_out   (mem_out),
    .mem_outb  (mem_outb)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic       rst;
    logic       st;
    logic       vf;
    logic       vld;
    logic [1:0] dat;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic       er;
    logic [7:0] mem;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic st, input logic vf, input logic vld,
                              input logic [1:0] dat, input logic rdy, input logic bsy,
                              input logic dn, input logic er, input logic [7:0] mem);
    vec_t v;
    v.rst = rst; v.st = st; v.vf = vf; v.vld = vld; v.dat = dat;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.er = er; v.mem = mem;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic vf, input logic vld,
                      input logic [1:0] dat);
    pReset    = rst;
    start     = st;
    verify    = vf;
    cfg_valid = vld;
    cfg_data  = dat;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic rdy, input logic bsy, input logic dn,
                            input logic er, input logic [7:0] mem);
    logic [7:0] memb;
    memb = ~mem;
    chk1({tag, " cfg_ready"}, cfg_ready, rdy);
    chk1({tag, " busy"}, busy, bsy);
    chk1({tag, " done"}, done, dn);
    chk1({tag, " err"}, err, er);
    chk8({tag, " mem_out"}, mem_out, mem);
    chk8({tag, " mem_outb"}, mem_outb, memb);
  endtask

  vec_t tbl [21];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pReset = 1'b1; start = 1'b0; verify = 1'b0; cfg_valid = 1'b0; cfg_data = 2'b00;

    //              rst   st    vf    vld   dat    rdy   bsy   dn    er    mem
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // reset
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); // valid in IDLE ignored
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); // load start
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h15);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2B); // DONE
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2B); // start in DONE dropped
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2B); // still IDLE
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2B); // verify start
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h47);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h8E);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1D);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h2B);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2B);
    tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2B); // verify, bad beat 2
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h47);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h8E);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1D);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h2B);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B); // err sticky

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].vf, tbl[i].vld, tbl[i].dat);
      expect_all($sformatf("row%0d", i), tbl[i].rdy, tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].mem);
    end

    // Load with a 3-cycle stall and a stray start; err stays set through a load.
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); expect_all("stall start", 1'b1, 1'b1, 1'b0, 1'b1, 8'h2B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("stall b1", 1'b1, 1'b1, 1'b0, 1'b1, 8'h47);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00); expect_all("stall b2", 1'b1, 1'b1, 1'b0, 1'b1, 8'h8E);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b11); expect_all("stall s1", 1'b1, 1'b1, 1'b0, 1'b1, 8'h8E);
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10); expect_all("stall s2", 1'b1, 1'b1, 1'b0, 1'b1, 8'h8E);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b01); expect_all("stall s3", 1'b1, 1'b1, 1'b0, 1'b1, 8'h8E);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11); expect_all("stall b3", 1'b1, 1'b1, 1'b0, 1'b1, 8'h1D);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("stall b4", 1'b0, 1'b1, 1'b1, 1'b1, 8'h2B);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00); expect_all("stall idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B);

    // A verify start clears err immediately.
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00); expect_all("vclr start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h2B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("vclr b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h47);

    // Reset mid-shift, colliding with a beat and a start, wins.
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11); expect_all("rst mid", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11); expect_all("rst idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); expect_all("ld2 start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("ld2 b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00); expect_all("ld2 b2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'b11); expect_all("ld2 rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00); expect_all("ld3 start", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("ld3 b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00); expect_all("ld3 b2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11); expect_all("ld3 b3", 1'b1, 1'b1, 1'b0, 1'b0, 8'h15);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b01); expect_all("ld3 b4", 1'b0, 1'b1, 1'b1, 1'b0, 8'h2B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b10); expect_all("ld3 idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h2B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
